// File: rtl/ecc_apb_reg_bank.sv
// APB register bank driving NUM_CH ECC cores, with one 256-byte register window per channel.
// Optional feature macro: ECC_BANK_IRQ_EN adds the irq output and a per-channel IRQ_EN register at 0x18.
module ecc_apb_reg_bank #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_CH          = 4,
  parameter int WAIT_STATES     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AMBA_ADDR_WIDTH-1:0]   paddr,
  input  logic                         pwrite,
  input  logic                         psel,
  input  logic                         penable,
  input  logic [AMBA_WORD-1:0]         pwdata,
  output logic [AMBA_WORD-1:0]         prdata,
  output logic                         pready,
  output logic                         pslverr,
  output logic [NUM_CH*2-1:0]          ch_sel,
  output logic [NUM_CH*DATA_WIDTH-1:0] ch_data_in,
  output logic [NUM_CH*2-1:0]          ch_cw_width,
  output logic [NUM_CH*DATA_WIDTH-1:0] ch_noise,
  output logic [NUM_CH-1:0]            ch_start,
  input  logic [NUM_CH-1:0]            operation_done,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  input  logic [NUM_CH*2-1:0]          num_of_errors
`ifdef ECC_BANK_IRQ_EN
  ,
  output logic                         irq
`endif
);

  localparam int CHN_W = AMBA_ADDR_WIDTH - 8;

  typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_e;
  typedef enum logic [1:0] {CH_IDLE, CH_BUSY, CH_DONE} ch_state_e;

  apb_state_e apb_state_q, apb_state_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      apb_state_q <= APB_IDLE;
      wait_cnt_q  <= 3'd0;
    end else begin
      apb_state_q <= apb_state_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  always_comb begin
    apb_state_d = apb_state_q;
    wait_cnt_d  = wait_cnt_q;
    case (apb_state_q)
      APB_IDLE: begin
        if (psel && !penable) apb_state_d = APB_SETUP;
      end
      APB_SETUP: begin
        if (!psel) begin
          apb_state_d = APB_IDLE;
        end else if (penable) begin
          apb_state_d = APB_ACCESS;
          wait_cnt_d  = 3'd0;
        end
      end
      APB_ACCESS: begin
        if (!psel || pready) apb_state_d = APB_IDLE;
        else                 wait_cnt_d  = wait_cnt_q + 3'd1;
      end
      default: apb_state_d = APB_IDLE;
    endcase
  end

  // pready decodes registered state only, so it is 0 out of reset.
  assign pready = (apb_state_q == APB_ACCESS) && (wait_cnt_q == 3'(WAIT_STATES));

  logic [7:0]       offset;
  logic [CHN_W-1:0] chan;
  logic             chan_ok;
  logic             is_ctrl, is_din, is_cw, is_noise, is_status, is_dout, is_irqen, mapped;

  assign offset    = paddr[7:0];
  assign chan      = paddr[AMBA_ADDR_WIDTH-1:8];
  assign chan_ok   = chan < CHN_W'(NUM_CH);
  assign is_ctrl   = offset == 8'h00;
  assign is_din    = offset == 8'h04;
  assign is_cw     = offset == 8'h08;
  assign is_noise  = offset == 8'h0C;
  assign is_status = offset == 8'h10;
  assign is_dout   = offset == 8'h14;
`ifdef ECC_BANK_IRQ_EN
  assign is_irqen  = offset == 8'h18;
`else
  assign is_irqen  = 1'b0;
`endif
  assign mapped = is_ctrl | is_din | is_cw | is_noise | is_status | is_dout | is_irqen;

  logic [NUM_CH-1:0]    busy_vec;
  logic [NUM_CH-1:0]    done_vec;
  logic [AMBA_WORD-1:0] rd_ch [NUM_CH];
  logic                 sel_busy;
  logic [AMBA_WORD-1:0] sel_rd;

  always_comb begin
    sel_busy = 1'b0;
    sel_rd   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (chan == CHN_W'(c)) begin
        sel_busy = sel_busy | busy_vec[c];
        sel_rd   = sel_rd | rd_ch[c];
      end
    end
  end

  logic err, xfer, wr_ok, rd_ok;

  assign err = !chan_ok || !mapped
             || (pwrite && (is_status || is_dout))
             || (pwrite && (is_ctrl || is_cw) && (pwdata[1:0] == 2'd3))
             || (pwrite && is_ctrl && sel_busy);
  assign xfer    = psel && penable && pready;
  assign wr_ok   = xfer && pwrite && !err;
  assign rd_ok   = xfer && !pwrite && !err;
  assign pslverr = pready && err;
  assign prdata  = (pready && !pwrite && !err) ? sel_rd : '0;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      ch_state_e             st_q, st_d;
      logic [1:0]            op_q, cw_q, nerr_q;
      logic [DATA_WIDTH-1:0] din_q, noise_q, dout_q;
      logic                  start_q;
      logic                  hit, wr_ctrl, rd_status, capture;

      assign hit       = chan == CHN_W'(gi);
      assign wr_ctrl   = wr_ok && hit && is_ctrl;
      assign rd_status = rd_ok && hit && is_status;
      assign capture   = (st_q == CH_BUSY) && operation_done[gi];

      always_comb begin
        st_d = st_q;
        case (st_q)
          CH_IDLE: if (wr_ctrl) st_d = CH_BUSY;
          CH_BUSY: if (operation_done[gi]) st_d = CH_DONE;
          CH_DONE: begin
            if (wr_ctrl)        st_d = CH_BUSY;
            else if (rd_status) st_d = CH_IDLE;
          end
          default: st_d = CH_IDLE;
        endcase
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          st_q    <= CH_IDLE;
          op_q    <= 2'd0;
          cw_q    <= 2'd0;
          nerr_q  <= 2'd0;
          din_q   <= '0;
          noise_q <= '0;
          dout_q  <= '0;
          start_q <= 1'b0;
        end else begin
          st_q    <= st_d;
          start_q <= wr_ctrl;
          if (wr_ctrl)                   op_q    <= pwdata[1:0];
          if (wr_ok && hit && is_cw)     cw_q    <= pwdata[1:0];
          if (wr_ok && hit && is_din)    din_q   <= pwdata[DATA_WIDTH-1:0];
          if (wr_ok && hit && is_noise)  noise_q <= pwdata[DATA_WIDTH-1:0];
          if (capture) begin
            dout_q <= data_out[gi*DATA_WIDTH +: DATA_WIDTH];
            nerr_q <= num_of_errors[gi*2 +: 2];
          end
        end
      end

      assign busy_vec[gi] = st_q == CH_BUSY;
      assign done_vec[gi] = st_q == CH_DONE;

`ifdef ECC_BANK_IRQ_EN
      logic irq_en_q;
      always_ff @(posedge clk) begin
        if (rst)                          irq_en_q <= 1'b0;
        else if (wr_ok && hit && is_irqen) irq_en_q <= pwdata[0];
      end
`endif

      always_comb begin
        rd_ch[gi] = '0;
        if (is_ctrl)   rd_ch[gi] = AMBA_WORD'(op_q);
        if (is_din)    rd_ch[gi] = AMBA_WORD'(din_q);
        if (is_cw)     rd_ch[gi] = AMBA_WORD'(cw_q);
        if (is_noise)  rd_ch[gi] = AMBA_WORD'(noise_q);
        if (is_status) rd_ch[gi] = AMBA_WORD'({nerr_q, done_vec[gi], busy_vec[gi]});
        if (is_dout)   rd_ch[gi] = AMBA_WORD'(dout_q);
`ifdef ECC_BANK_IRQ_EN
        if (is_irqen)  rd_ch[gi] = AMBA_WORD'(irq_en_q);
`endif
      end

      assign ch_sel[gi*2 +: 2]                       = op_q;
      assign ch_cw_width[gi*2 +: 2]                  = cw_q;
      assign ch_data_in[gi*DATA_WIDTH +: DATA_WIDTH] = din_q;
      assign ch_noise[gi*DATA_WIDTH +: DATA_WIDTH]   = noise_q;
      assign ch_start[gi]                            = start_q;
    end
  endgenerate

`ifdef ECC_BANK_IRQ_EN
  logic [NUM_CH-1:0] irq_src;
  logic              irq_q;
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_irq
    assign irq_src[gi] = done_vec[gi] & g_ch[gi].irq_en_q;
  end
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= |irq_src;
  end
  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_ecc_apb_reg_bank.sv
// Directed bench for ecc_apb_reg_bank: a zero-wait instance for the register/channel behaviour
// and a WAIT_STATES=3 instance for the wait-state and abort timing.
module tb_ecc_apb_reg_bank;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] paddr = '0;
  logic          pwrite = 1'b0;
  logic          psel = 1'b0, penable = 1'b0;
  logic          psel2 = 1'b0, penable2 = 1'b0;
  logic [31:0]   pwdata = '0;
  logic [NC-1:0]    operation_done = '0;
  logic [NC*DW-1:0] data_out = '0;
  logic [NC*2-1:0]  num_of_errors = '0;

  logic [31:0]      prdata, prdata_ws;
  logic             pready, pslverr, pready_ws, pslverr_ws;
  logic [NC*2-1:0]  ch_sel, ch_cw_width, ch_sel_ws, ch_cw_ws;
  logic [NC*DW-1:0] ch_data_in, ch_noise, ch_data_in_ws, ch_noise_ws;
  logic [NC-1:0]    ch_start, ch_start_ws;
`ifdef ECC_BANK_IRQ_EN
  logic irq, irq_ws;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ecc_apb_reg_bank #(.AMBA_ADDR_WIDTH(AW), .AMBA_WORD(32), .DATA_WIDTH(DW),
                     .NUM_CH(NC), .WAIT_STATES(0)) dut (
    .clk(clk), .rst(rst), .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .ch_sel(ch_sel), .ch_data_in(ch_data_in), .ch_cw_width(ch_cw_width), .ch_noise(ch_noise),
    .ch_start(ch_start), .operation_done(operation_done), .data_out(data_out),
    .num_of_errors(num_of_errors)
`ifdef ECC_BANK_IRQ_EN
    , .irq(irq)
`endif
  );

  ecc_apb_reg_bank #(.AMBA_ADDR_WIDTH(AW), .AMBA_WORD(32), .DATA_WIDTH(DW),
                     .NUM_CH(NC), .WAIT_STATES(3)) dut_ws (
    .clk(clk), .rst(rst), .paddr(paddr), .pwrite(pwrite), .psel(psel2), .penable(penable2),
    .pwdata(pwdata), .prdata(prdata_ws), .pready(pready_ws), .pslverr(pslverr_ws),
    .ch_sel(ch_sel_ws), .ch_data_in(ch_data_in_ws), .ch_cw_width(ch_cw_ws), .ch_noise(ch_noise_ws),
    .ch_start(ch_start_ws), .operation_done(operation_done), .data_out(data_out),
    .num_of_errors(num_of_errors)
`ifdef ECC_BANK_IRQ_EN
    , .irq(irq_ws)
`endif
  );

  // One APB transfer on the zero-wait instance; returns read data and slave error.
  task automatic apb_xfer(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    int n;
    @(posedge clk); #1;
    paddr = addr; pwrite = wr; pwdata = wdata; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    while (!pready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (!pready) begin
      $display("FAIL apb_timeout addr=%h: pready never rose", addr);
      n_fail++;
    end
    rdata = prdata;
    err   = pslverr;
    $display("xfer %s addr=%h wdata=%h rdata=%h err=%0b", wr ? "WR" : "RD", addr, wdata, rdata, err);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // One transfer on the wait-state instance; returns cycles from penable to pready.
  task automatic apb2_xfer(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wdata,
                           output int cycles);
    @(posedge clk); #1;
    paddr = addr; pwrite = wr; pwdata = wdata; psel2 = 1'b1; penable2 = 1'b0;
    @(posedge clk); #1;
    penable2 = 1'b1;
    cycles = 0;
    while (!pready_ws && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    $display("xfer_ws addr=%h wdata=%h cycles=%0d err=%0b", addr, wdata, cycles, pslverr_ws);
    @(posedge clk); #1;
    psel2 = 1'b0; penable2 = 1'b0;
  endtask

  task automatic pulse_done(input int ch, input logic [31:0] d, input logic [1:0] ne);
    @(posedge clk); #1;
    data_out[ch*DW +: DW] = d;
    num_of_errors[ch*2 +: 2] = ne;
    operation_done[ch] = 1'b1;
    @(posedge clk); #1;
    operation_done = '0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({prdata, pready, pslverr, ch_start, ch_sel, ch_cw_width} !== '0
        || ch_data_in !== '0 || ch_noise !== '0 || pready_ws !== 1'b0 || ch_start_ws !== '0) begin
      $display("FAIL reset_outputs: prdata=%h pready=%b pslverr=%b ch_start=%b ch_sel=%h want all 0",
               prdata, pready, pslverr, ch_start, ch_sel);
      n_fail++;
    end
    rst = 1'b0;
    apb_xfer(20'h00010, 1'b0, 32'h0, rd, err);
    n_checks++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      $display("FAIL reset_status: got %h err=%b want 0 err=0", rd, err);
      n_fail++;
    end
  endtask

  task automatic test_full_flow();
    logic [31:0] rd; logic err;
    apb_xfer(20'h00004, 1'b1, 32'hA5, rd, err);
    apb_xfer(20'h00008, 1'b1, 32'h0, rd, err);
    apb_xfer(20'h0000C, 1'b1, 32'h1, rd, err);
    apb_xfer(20'h00000, 1'b1, 32'h2, rd, err);
    n_checks++;
    if (err !== 1'b0 || ch_start !== 4'b0001) begin
      $display("FAIL flow_start: ch_start=%b err=%b want 0001 err=0", ch_start, err);
      n_fail++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (ch_start !== 4'b0000) begin
      $display("FAIL flow_start_once: ch_start=%b want 0000", ch_start);
      n_fail++;
    end
    n_checks++;
    if (ch_sel[1:0] !== 2'd2 || ch_data_in[31:0] !== 32'hA5 || ch_noise[31:0] !== 32'h1
        || ch_cw_width[1:0] !== 2'd0) begin
      $display("FAIL flow_config: sel=%0d din=%h noise=%h cw=%0d want 2 a5 1 0",
               ch_sel[1:0], ch_data_in[31:0], ch_noise[31:0], ch_cw_width[1:0]);
      n_fail++;
    end
    apb_xfer(20'h00010, 1'b0, 32'h0, rd, err);
    n_checks++;
    if (rd !== 32'h1) begin
      $display("FAIL flow_status_busy: got %h want 1", rd);
      n_fail++;
    end
    pulse_done(0, 32'hA5, 2'd1);
    apb_xfer(20'h00010, 1'b0, 32'h0, rd, err);
    n_checks++;
    if (rd !== 32'h6) begin
      $display("FAIL flow_status_done: got %h want 6", rd);
      n_fail++;
    end
    apb_xfer(20'h00014, 1'b0, 32'h0, rd, err);
    n_checks++;
    if (rd !== 32'hA5) begin
      $display("FAIL flow_data_out: got %h want a5", rd);
      n_fail++;
    end
    apb_xfer(20'h00010, 1'b0, 32'h0, rd, err);
    n_checks++;
    if (rd !== 32'h4) begin
      $display("FAIL flow_status_cleared: got %h want 4", rd);
      n_fail++;
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err;
    apb_xfer(20'h00000, 1'b1, 32'h3, rd, err);
    n_checks++;
    if (err !== 1'b1 || ch_start !== 4'b0000 || ch_sel[1:0] !== 2'd2) begin
      $display("FAIL err_illegal_op: err=%b ch_start=%b sel=%0d want 1 0000 2", err, ch_start, ch_sel[1:0]);
      n_fail++;
    end
    apb_xfer(20'h00010, 1'b1, 32'h7, rd, err);
    n_checks++;
    if (err !== 1'b1) begin
      $display("FAIL err_ro_write: err=%b want 1", err);
      n_fail++;
    end
    apb_xfer(20'h00008, 1'b1, 32'h3, rd, err);
    n_checks++;
    if (err !== 1'b1 || ch_cw_width[1:0] !== 2'd0) begin
      $display("FAIL err_illegal_cw: err=%b cw=%0d want 1 0", err, ch_cw_width[1:0]);
      n_fail++;
    end
    apb_xfer(20'(NC << 8) + 20'h4, 1'b0, 32'h0, rd, err);
    n_checks++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      $display("FAIL err_bad_channel: err=%b rd=%h want 1 0", err, rd);
      n_fail++;
    end
    apb_xfer(20'h0001C, 1'b0, 32'h0, rd, err);
    n_checks++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      $display("FAIL err_unmapped: err=%b rd=%h want 1 0", err, rd);
      n_fail++;
    end
`ifndef ECC_BANK_IRQ_EN
    apb_xfer(20'h00018, 1'b1, 32'h1, rd, err);
    n_checks++;
    if (err !== 1'b1) begin
      $display("FAIL err_irq_en_absent: err=%b want 1", err);
      n_fail++;
    end
`endif
  endtask

  task automatic test_busy_guard();
    logic [31:0] rd; logic err;
    apb_xfer(20'h00100, 1'b1, 32'h0, rd, err);
    n_checks++;
    if (err !== 1'b0 || ch_start !== 4'b0010) begin
      $display("FAIL busy_first_start: err=%b ch_start=%b want 0 0010", err, ch_start);
      n_fail++;
    end
    apb_xfer(20'h00100, 1'b1, 32'h1, rd, err);
    n_checks++;
    if (err !== 1'b1 || ch_start !== 4'b0000 || ch_sel[3:2] !== 2'd0) begin
      $display("FAIL busy_guard: err=%b ch_start=%b sel=%0d want 1 0000 0", err, ch_start, ch_sel[3:2]);
      n_fail++;
    end
    apb_xfer(20'h00104, 1'b1, 32'h1234, rd, err);
    n_checks++;
    if (err !== 1'b0 || ch_data_in[63:32] !== 32'h1234) begin
      $display("FAIL busy_config_write: err=%b din=%h want 0 1234", err, ch_data_in[63:32]);
      n_fail++;
    end
    apb_xfer(20'h00200, 1'b1, 32'h1, rd, err);
    n_checks++;
    if (err !== 1'b0 || ch_start !== 4'b0100 || ch_sel[5:4] !== 2'd1) begin
      $display("FAIL busy_other_channel: err=%b ch_start=%b sel=%0d want 0 0100 1", err, ch_start, ch_sel[5:4]);
      n_fail++;
    end
  endtask

  task automatic test_done_collision();
    logic [31:0] rd; logic err;
    @(posedge clk); #1;
    paddr = 20'h00110; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    data_out[63:32] = 32'h5A5A; num_of_errors[3:2] = 2'd2; operation_done[1] = 1'b1;
    rd = prdata;
    n_checks++;
    if (pready !== 1'b1 || rd !== 32'h1) begin
      $display("FAIL collision_read: pready=%b rd=%h want 1 1", pready, rd);
      n_fail++;
    end
    @(posedge clk); #1;
    operation_done = '0; psel = 1'b0; penable = 1'b0;
    apb_xfer(20'h00110, 1'b0, 32'h0, rd, err);
    n_checks++;
    if (rd !== 32'hA) begin
      $display("FAIL collision_done_set: got %h want a", rd);
      n_fail++;
    end
    pulse_done(3, 32'hDEAD, 2'd3);
    apb_xfer(20'h00314, 1'b0, 32'h0, rd, err);
    n_checks++;
    if (rd !== 32'h0) begin
      $display("FAIL done_while_idle: data_out=%h want 0", rd);
      n_fail++;
    end
  endtask

  task automatic test_wait_states();
    int cyc;
    apb2_xfer(20'h00004, 1'b1, 32'hC3, cyc);
    n_checks++;
    if (cyc !== 4 || ch_data_in_ws[31:0] !== 32'hC3) begin
      $display("FAIL ws_latency: cycles=%0d din=%h want 4 c3", cyc, ch_data_in_ws[31:0]);
      n_fail++;
    end
    @(posedge clk); #1;
    paddr = 20'h0000C; pwrite = 1'b1; pwdata = 32'h77; psel2 = 1'b1; penable2 = 1'b0;
    @(posedge clk); #1;
    penable2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    psel2 = 1'b0; penable2 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (ch_noise_ws[31:0] !== 32'h0 || pready_ws !== 1'b0) begin
      $display("FAIL ws_abort: noise=%h pready=%b want 0 0", ch_noise_ws[31:0], pready_ws);
      n_fail++;
    end
    apb2_xfer(20'h0000C, 1'b1, 32'h99, cyc);
    n_checks++;
    if (cyc !== 4 || ch_noise_ws[31:0] !== 32'h99) begin
      $display("FAIL ws_after_abort: cycles=%0d noise=%h want 4 99", cyc, ch_noise_ws[31:0]);
      n_fail++;
    end
  endtask

  task automatic test_reset_busy();
    logic [31:0] rd; logic err;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    apb_xfer(20'h00210, 1'b0, 32'h0, rd, err);
    n_checks++;
    if (rd !== 32'h0 || ch_sel !== '0 || ch_start !== '0) begin
      $display("FAIL reset_mid_busy: status=%h sel=%h start=%b want 0", rd, ch_sel, ch_start);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_full_flow();
    test_errors();
    test_busy_guard();
    test_done_collision();
    test_wait_states();
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
